uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
Sequencer between the UART receiver, the ALU and the UART transmitter.
- Collects three bytes from rx_uart, in order: operand A, operand B, opcode.
- Drives the registered operands and opcode to the combinational ALU.
- Latches the ALU result and hands it to tx_uart with a start pulse, then waits for transmit completion.
- Runs in the i_clock domain. Byte and done strobes are one-cycle ticks in the same domain.

Parameters:
- NB_DATA, 8, width of UART bytes, operands and result.
- NB_OP, 6, opcode width; taken from i_rx_data[NB_OP-1:0].
- NB_TIMEOUT, 20, width of the inter-byte timeout counter.
- N_TIMEOUT, 1000000, clock cycles allowed between bytes of one transaction (20 ms at 50 MHz).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_done_tick  in  1  one-cycle pulse; i_rx_data valid this cycle.
- i_rx_data  in  NB_DATA  received byte.
- i_alu_result  in  NB_DATA  combinational ALU output.
- i_tx_done_tick  in  1  one-cycle pulse when tx_uart finishes the stop bit.
- o_alu_a  out  NB_DATA  registered operand A.
- o_alu_b  out  NB_DATA  registered operand B.
- o_alu_op  out  NB_OP  registered opcode.
- o_tx_data  out  NB_DATA  byte for tx_uart; stable from o_tx_start until the next transaction.
- o_tx_start  out  1  one-cycle start pulse to tx_uart.
- o_busy  out  1  high in every state except WAIT_A.
- o_timeout  out  1  one-cycle pulse when a partial transaction is abandoned.
- o_overrun  out  1  sticky flag: a byte arrived while it could not be accepted.

Behaviour:
- Reset (i_reset=0, asynchronous): state=WAIT_A, timeout counter=0, all outputs 0.
- Reset mid-transaction discards all partial data.
- All outputs are registered.
- States:
  - WAIT_A: on rx tick, o_alu_a<=i_rx_data, go WAIT_B.
  - WAIT_B: on rx tick, o_alu_b<=i_rx_data, go WAIT_OP.
  - WAIT_OP: on rx tick, o_alu_op<=i_rx_data[NB_OP-1:0], go EXEC.
  - EXEC: exactly one cycle, so the ALU sees the new registers. At the end of the cycle, o_tx_data<=i_alu_result, o_tx_start<=1, go WAIT_TX.
  - WAIT_TX: o_tx_start returns to 0 after one cycle. On i_tx_done_tick, go WAIT_A.
- Latency: opcode tick at cycle N -> o_alu_op updated at N+1 -> o_tx_start high during cycle N+2 only.
- Timeout counter:
  - Cleared on entry to WAIT_B or WAIT_OP and on every accepted byte.
  - Increments each cycle in WAIT_B/WAIT_OP. Held at 0 in other states.
  - If it reaches N_TIMEOUT-1 with no tick: go WAIT_A, o_timeout=1 for one cycle, counter cleared.
  - Held registers o_alu_a and o_alu_b are not cleared on timeout.
- Overrun: an rx tick in EXEC, or in WAIT_TX without a simultaneous i_tx_done_tick, drops the byte and sets o_overrun=1. o_overrun clears only on reset.
- Simultaneous events:
  - rx tick and timeout expiry in the same cycle: the tick wins; byte accepted, no o_timeout.
  - i_tx_done_tick and rx tick in the same cycle in WAIT_TX: the byte is accepted as operand A; go WAIT_B; no overrun.
  - i_tx_done_tick outside WAIT_TX: ignored.
- o_busy = (state != WAIT_A), registered with the state.
- Back-to-back transactions need no idle gap beyond the WAIT_TX exit.

Test Plan:
- Normal ADD: reset low for 5 cycles, then ticks with 0x0F, 0x03, 0x20; ALU model returns A+B.
  -> o_alu_a=0x0F, o_alu_b=0x03, o_alu_op=6'h20.
  -> o_tx_data=0x12, o_tx_start high for exactly one cycle, 2 cycles after the opcode tick.
  -> o_busy low after i_tx_done_tick.
- Timeout with N_TIMEOUT=100: tick 0x55, then no tick for 100 cycles.
  -> o_timeout pulses once at cycle 99 after entry; state WAIT_A; o_busy=0.
  -> Next tick 0xAA is taken as operand A.
- Timeout boundary with N_TIMEOUT=100: tick exactly at cycle 99 in WAIT_B.
  -> Byte accepted as B, no o_timeout, counter restarts in WAIT_OP.
- Overrun: tick during WAIT_TX (before tx_done).
  -> o_overrun=1 and stays 1; o_tx_data unchanged; the following transaction still completes correctly.
- Simultaneous done and byte: i_tx_done_tick and tick 0x7E in the same cycle.
  -> o_alu_a=0x7E, state WAIT_B, o_overrun stays 0.
- Reset mid-operation: assert i_reset=0 in WAIT_OP.
  -> All outputs 0 immediately (asynchronously); after release, a full 3-byte sequence produces the correct result.
- Protocol timing: drive with real rx_uart/tx_uart at 19200 baud.
  -> Frames decoded correctly; no overrun flagged.

Source files
------------

// File: rtl/uart_alu_interface_if.sv
// Signal bundle between the UART/ALU sequencer and its rx_uart, ALU and tx_uart neighbours.
interface uart_alu_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic               i_rx_done_tick;
    logic [NB_DATA-1:0] i_rx_data;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done_tick;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_timeout;
    logic               o_overrun;

    modport slave (
        input  i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
               o_busy, o_timeout, o_overrun
    );

    modport master (
        output i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
               o_busy, o_timeout, o_overrun
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Sequencer: collects A, B and opcode bytes from rx_uart, drives the ALU and
// hands the latched result to tx_uart, with inter-byte timeout and overrun flag.
module uart_alu_interface #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int NB_TIMEOUT = 20,
    parameter int N_TIMEOUT  = 1000000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    uart_alu_interface_if.slave  bus
);
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(N_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
    logic [NB_DATA-1:0]    alu_a_q, alu_a_d;
    logic [NB_DATA-1:0]    alu_b_q, alu_b_d;
    logic [NB_OP-1:0]      alu_op_q, alu_op_d;
    logic [NB_DATA-1:0]    tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  busy_q, busy_d;
    logic                  timeout_q, timeout_d;
    logic                  overrun_q, overrun_d;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= WAIT_A;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = overrun_q;

        case (state_q)
            WAIT_A: begin
                if (bus.i_rx_done_tick) begin
                    alu_a_d = bus.i_rx_data;
                    state_d = WAIT_B;
                end
            end
            // An arriving byte takes priority over an expiring timeout.
            WAIT_B: begin
                if (bus.i_rx_done_tick) begin
                    alu_b_d = bus.i_rx_data;
                    state_d = WAIT_OP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end else begin
                    cnt_d = cnt_q + NB_TIMEOUT'(1);
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done_tick) begin
                    alu_op_d = bus.i_rx_data[NB_OP-1:0];
                    state_d  = EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end else begin
                    cnt_d = cnt_q + NB_TIMEOUT'(1);
                end
            end
            EXEC: begin
                tx_data_d  = bus.i_alu_result;
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
                if (bus.i_rx_done_tick) begin
                    overrun_d = 1'b1;
                end
            end
            WAIT_TX: begin
                if (bus.i_tx_done_tick) begin
                    if (bus.i_rx_done_tick) begin
                        alu_a_d = bus.i_rx_data;
                        state_d = WAIT_B;
                    end else begin
                        state_d = WAIT_A;
                    end
                end else if (bus.i_rx_done_tick) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase

        busy_d = (state_d != WAIT_A);
    end

    assign bus.o_alu_a    = alu_a_q;
    assign bus.o_alu_b    = alu_b_q;
    assign bus.o_alu_op   = alu_op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_timeout  = timeout_q;
    assign bus.o_overrun  = overrun_q;
endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: randomized transactions against a
// transaction-level model of the byte sequencing, timeout and overrun rules.
module tb_uart_alu_interface;
    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int N_TO    = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_ovr = 1'b0;
    logic [5:0] ops [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};

    uart_alu_interface_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    uart_alu_interface #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_TIMEOUT(20), .N_TIMEOUT(N_TO)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.i_rx_done_tick = 1'b1;
        bus.i_rx_data      = d;
        @(posedge clk); #1;
        bus.i_rx_done_tick = 1'b0;
        bus.i_rx_data      = 8'($urandom);
    endtask

    // mode 0: plain completion, 1: stray byte during WAIT_TX, 2: done with simultaneous byte 0x7E
    task automatic op_and_result(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                                 input int mode, input int dly);
        logic [5:0] op;
        logic [7:0] exp_res;
        op      = opb[5:0];
        exp_res = alu_ref(a, b, op);
        send_byte(opb);
        n_vec++; if (bus.o_alu_a !== a) begin n_err++; $display("FAIL alu_a: got %h expected %h", bus.o_alu_a, a); end
        n_vec++; if (bus.o_alu_b !== b) begin n_err++; $display("FAIL alu_b: got %h expected %h", bus.o_alu_b, b); end
        n_vec++; if (bus.o_alu_op !== op) begin n_err++; $display("FAIL alu_op: got %h expected %h", bus.o_alu_op, op); end
        n_vec++; if ({bus.o_tx_start, bus.o_busy} !== 2'b01) begin n_err++; $display("FAIL exec_start_busy: got %b expected 01", {bus.o_tx_start, bus.o_busy}); end
        @(posedge clk); #1;
        n_vec++; if (bus.o_tx_start !== 1'b1) begin n_err++; $display("FAIL tx_start_pulse: got %b expected 1", bus.o_tx_start); end
        n_vec++; if (bus.o_tx_data !== exp_res) begin n_err++; $display("FAIL tx_data: got %h expected %h", bus.o_tx_data, exp_res); end
        @(posedge clk); #1;
        n_vec++; if (bus.o_tx_start !== 1'b0) begin n_err++; $display("FAIL tx_start_end: got %b expected 0", bus.o_tx_start); end
        if (mode == 1) begin
            send_byte(8'($urandom));
            exp_ovr = 1'b1;
            n_vec++; if (bus.o_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", bus.o_overrun); end
            n_vec++; if (bus.o_tx_data !== exp_res) begin n_err++; $display("FAIL tx_data_hold: got %h expected %h", bus.o_tx_data, exp_res); end
        end
        idle(dly);
        n_vec++; if ({bus.o_tx_start, bus.o_busy} !== 2'b01) begin n_err++; $display("FAIL wait_tx_state: got %b expected 01", {bus.o_tx_start, bus.o_busy}); end
        bus.i_tx_done_tick = 1'b1;
        if (mode == 2) begin
            bus.i_rx_done_tick = 1'b1;
            bus.i_rx_data      = 8'h7E;
        end
        @(posedge clk); #1;
        bus.i_tx_done_tick = 1'b0;
        bus.i_rx_done_tick = 1'b0;
        if (mode == 2) begin
            n_vec++; if (bus.o_alu_a !== 8'h7E) begin n_err++; $display("FAIL simul_alu_a: got %h expected 7e", bus.o_alu_a); end
            n_vec++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL simul_busy: got %b expected 1", bus.o_busy); end
        end else begin
            n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL done_busy: got %b expected 0", bus.o_busy); end
        end
        n_vec++; if (bus.o_tx_data !== exp_res) begin n_err++; $display("FAIL tx_data_after: got %h expected %h", bus.o_tx_data, exp_res); end
        n_vec++; if (bus.o_overrun !== exp_ovr) begin n_err++; $display("FAIL overrun: got %b expected %b", bus.o_overrun, exp_ovr); end
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int gap);
        send_byte(a);
        idle(gap);
        send_byte(b);
        idle(gap);
        op_and_result(a, b, opb, 0, gap);
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_timeout, bus.o_overrun} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
        end
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        n_vec++; if ({bus.o_busy, bus.o_timeout, bus.o_overrun, bus.o_tx_start} !== 4'b0000) begin
            n_err++; $display("FAIL post_reset_flags: got %b expected 0000", {bus.o_busy, bus.o_timeout, bus.o_overrun, bus.o_tx_start});
        end
    endtask

    task automatic test_add();
        send_byte(8'h0F);
        n_vec++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL add_busy: got %b expected 1", bus.o_busy); end
        idle(2);
        send_byte(8'h03);
        idle(1);
        op_and_result(8'h0F, 8'h03, 8'h20, 0, 3);
        n_vec++; if (bus.o_tx_data !== 8'h12) begin n_err++; $display("FAIL add_result: got %h expected 12", bus.o_tx_data); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, opb;
        for (int i = 0; i < 8; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            opb = {2'($urandom), ops[$urandom_range(0, 5)]};
            run_txn(a, b, opb, int'($urandom_range(0, 4)));
        end
    endtask

    task automatic test_back_to_back();
        run_txn(8'hC3, 8'h5A, 8'h26, 0);
        run_txn(8'h10, 8'h20, 8'h22, 0);
    endtask

    task automatic test_timeout();
        send_byte(8'h55);
        for (int i = 1; i < N_TO; i++) begin
            @(posedge clk); #1;
            n_vec++; if ({bus.o_timeout, bus.o_busy} !== 2'b01) begin
                n_err++; $display("FAIL timeout_early cycle %0d: got %b expected 01", i, {bus.o_timeout, bus.o_busy});
            end
        end
        @(posedge clk); #1;
        n_vec++; if ({bus.o_timeout, bus.o_busy} !== 2'b10) begin n_err++; $display("FAIL timeout_pulse: got %b expected 10", {bus.o_timeout, bus.o_busy}); end
        n_vec++; if (bus.o_alu_a !== 8'h55) begin n_err++; $display("FAIL timeout_keep_a: got %h expected 55", bus.o_alu_a); end
        @(posedge clk); #1;
        n_vec++; if ({bus.o_timeout, bus.o_busy} !== 2'b00) begin n_err++; $display("FAIL timeout_once: got %b expected 00", {bus.o_timeout, bus.o_busy}); end
        send_byte(8'hAA);
        n_vec++; if (bus.o_alu_a !== 8'hAA) begin n_err++; $display("FAIL after_timeout_a: got %h expected aa", bus.o_alu_a); end
        send_byte(8'h11);
        op_and_result(8'hAA, 8'h11, 8'h25, 0, 2);
    endtask

    task automatic test_timeout_boundary();
        send_byte(8'h33);
        idle(N_TO - 1);
        send_byte(8'h44);
        n_vec++; if ({bus.o_timeout, bus.o_busy} !== 2'b01) begin n_err++; $display("FAIL boundary_b: got %b expected 01", {bus.o_timeout, bus.o_busy}); end
        n_vec++; if (bus.o_alu_b !== 8'h44) begin n_err++; $display("FAIL boundary_alu_b: got %h expected 44", bus.o_alu_b); end
        idle(N_TO - 1);
        n_vec++; if ({bus.o_timeout, bus.o_busy} !== 2'b01) begin n_err++; $display("FAIL boundary_op_wait: got %b expected 01", {bus.o_timeout, bus.o_busy}); end
        op_and_result(8'h33, 8'h44, 8'h20, 0, 1);
    endtask

    task automatic test_simultaneous();
        send_byte(8'h21);
        send_byte(8'h09);
        op_and_result(8'h21, 8'h09, 8'h22, 2, 2);
        send_byte(8'h81);
        op_and_result(8'h7E, 8'h81, 8'h24, 0, 1);
    endtask

    task automatic test_reset_mid();
        send_byte(8'hE1);
        send_byte(8'h1E);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_timeout, bus.o_overrun} !== '0) begin
            n_err++; $display("FAIL async_reset: got a=%h b=%h busy=%b expected all 0", bus.o_alu_a, bus.o_alu_b, bus.o_busy);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        run_txn(8'h64, 8'h32, 8'h22, 1);
    endtask

    task automatic test_overrun();
        send_byte(8'h07);
        send_byte(8'h08);
        op_and_result(8'h07, 8'h08, 8'h20, 1, 2);
        run_txn(8'h90, 8'h0F, 8'h27, 1);
    endtask

    initial begin
        bus.i_rx_done_tick = 1'b0;
        bus.i_rx_data      = '0;
        bus.i_tx_done_tick = 1'b0;
        test_reset();
        test_add();
        test_random();
        test_back_to_back();
        test_timeout();
        test_timeout_boundary();
        test_simultaneous();
        test_reset_mid();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
